// File: rtl/lcd_bus_monitor.sv
// Passive HD44780-style bus monitor: shadows the 2x16 DDRAM,
// decodes a HH:MM:SS clock on line 1 and an alarm banner on line 2.
//
// Ports:
//   CLK, RESETN        clock, async active-low reset
//   LCD_DATA/E/RS      observed LCD bus (synchronous to CLK)
//   RD_ADDR, RD_CHAR   combinational shadow-cell read port
//   H10..S1            decoded time digits (4'hF = not a digit)
//   TIME_VALID         line 1 holds a well-formed time
//   ALARM_DET          line 2 shows "TIME IS OVER"
//   CURSOR             current write position (0-15 line 1, 16-31 line 2)
//   ERR, RUNT          sticky: bad DDRAM address / short E pulse
module lcd_bus_monitor #(
   parameter int unsigned E_MIN_HIGH = 2
) (
   input  logic       CLK,
   input  logic       RESETN,
   input  logic [7:0] LCD_DATA,
   input  logic       LCD_E,
   input  logic       LCD_RS,
   input  logic [4:0] RD_ADDR,
   output logic [7:0] RD_CHAR,
   output logic [3:0] H10,
   output logic [3:0] H1,
   output logic [3:0] M10,
   output logic [3:0] M1,
   output logic [3:0] S10,
   output logic [3:0] S1,
   output logic       TIME_VALID,
   output logic       ALARM_DET,
   output logic [4:0] CURSOR,
   output logic       ERR,
   output logic       RUNT
);

   localparam logic [95:0] ALARM_MSG = "TIME IS OVER";

   logic [7:0]  d_q;
   logic        rs_q;
   logic        e_q;
   logic [15:0] hi_cnt;
   logic [7:0]  cells [32];
   logic [4:0]  cursor;
   logic        entry_inc;
   logic        err;
   logic        runt;

   logic        strobe;
   logic        short_pulse;
   logic        alarm;

   // Falling edge of E: act on the bus values of the last high cycle.
   assign strobe      = e_q & ~LCD_E;
   assign short_pulse = hi_cnt < 16'(E_MIN_HIGH);

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         d_q       <= '0;
         rs_q      <= 1'b0;
         e_q       <= 1'b0;
         hi_cnt    <= '0;
         cursor    <= '0;
         entry_inc <= 1'b1;
         err       <= 1'b0;
         runt      <= 1'b0;
         for (int i = 0; i < 32; i++) cells[i] <= 8'h20;
      end else begin
         d_q  <= LCD_DATA;
         rs_q <= LCD_RS;
         e_q  <= LCD_E;
         if (!LCD_E)
            hi_cnt <= '0;
         else if (hi_cnt != 16'hFFFF)
            hi_cnt <= hi_cnt + 16'd1;

         if (strobe) begin
            if (short_pulse) begin
               runt <= 1'b1;
            end else if (rs_q) begin
               cells[cursor] <= d_q;
               cursor <= entry_inc ? cursor + 5'd1 : cursor - 5'd1;
            end else begin
               unique case (1'b1)
                  d_q[7]: begin
                     if (d_q[6:4] == 3'b000)
                        cursor <= {1'b0, d_q[3:0]};
                     else if (d_q[6:4] == 3'b100)
                        cursor <= {1'b1, d_q[3:0]};
                     else
                        err <= 1'b1;
                  end
                  (d_q == 8'h01): begin
                     cursor    <= '0;
                     entry_inc <= 1'b1;
                     for (int i = 0; i < 32; i++) cells[i] <= 8'h20;
                  end
                  (d_q[7:1] == 7'h01): cursor <= '0;
                  (d_q[7:2] == 6'h01): entry_inc <= d_q[1];
                  default: ;
               endcase
            end
         end
      end
   end

   function automatic logic [3:0] dig(input logic [7:0] ch);
      if (ch >= 8'h30 && ch <= 8'h39) return ch[3:0];
      return 4'hF;
   endfunction

   always_comb begin
      alarm = 1'b1;
      for (int i = 0; i < 12; i++)
         if (cells[18+i] != ALARM_MSG[95-8*i -: 8]) alarm = 1'b0;
   end

   assign RD_CHAR = cells[RD_ADDR];
   assign H10 = dig(cells[2]);
   assign H1  = dig(cells[3]);
   assign M10 = dig(cells[7]);
   assign M1  = dig(cells[8]);
   assign S10 = dig(cells[12]);
   assign S1  = dig(cells[13]);

   assign TIME_VALID = (H10 != 4'hF) && (H1 != 4'hF) &&
                       (M10 != 4'hF) && (M1 != 4'hF) &&
                       (S10 != 4'hF) && (S1 != 4'hF) &&
                       (cells[5] == 8'h3A) && (cells[10] == 8'h3A);
   assign ALARM_DET  = alarm;
   assign CURSOR     = cursor;
   assign ERR        = err;
   assign RUNT       = runt;

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Directed bench for lcd_bus_monitor: table-driven clock-screen write
// plus hand-written alarm, error, runt, entry-mode and reset sequences.
module tb_lcd_bus_monitor;

   logic       CLK = 1'b0;
   logic       RESETN = 1'b0;
   logic [7:0] LCD_DATA = '0;
   logic       LCD_E = 1'b0;
   logic       LCD_RS = 1'b0;
   logic [4:0] RD_ADDR = '0;
   logic [7:0] RD_CHAR;
   logic [3:0] H10, H1, M10, M1, S10, S1;
   logic       TIME_VALID, ALARM_DET, ERR, RUNT;
   logic [4:0] CURSOR;

   int checks = 0;
   int errors = 0;

   lcd_bus_monitor #(.E_MIN_HIGH(2)) dut (
      .CLK(CLK), .RESETN(RESETN),
      .LCD_DATA(LCD_DATA), .LCD_E(LCD_E), .LCD_RS(LCD_RS),
      .RD_ADDR(RD_ADDR), .RD_CHAR(RD_CHAR),
      .H10(H10), .H1(H1), .M10(M10), .M1(M1), .S10(S10), .S1(S1),
      .TIME_VALID(TIME_VALID), .ALARM_DET(ALARM_DET),
      .CURSOR(CURSOR), .ERR(ERR), .RUNT(RUNT)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic       rs;
      logic [7:0] data;
      logic [4:0] cur;
   } vec_t;

   vec_t tbl[21];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send(input logic rs, input logic [7:0] data,
                       input int hi);
      @(negedge CLK);
      LCD_RS = rs;
      LCD_DATA = data;
      LCD_E = 1'b1;
      repeat (hi) @(negedge CLK);
      LCD_E = 1'b0;
      @(negedge CLK);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(1'b1, s[i], 4);
   endtask

   task automatic chk_cell(input int a, input logic [7:0] exp);
      RD_ADDR = 5'(a);
      #1;
      chk($sformatf("cell%0d", a), RD_CHAR, exp);
   endtask

   initial begin
      string l1;
      l1 = "  12 : 34 : 56  ";
      tbl[0] = '{1'b0, 8'h38, 5'd0};
      tbl[1] = '{1'b0, 8'h0F, 5'd0};
      tbl[2] = '{1'b0, 8'h06, 5'd0};
      tbl[3] = '{1'b0, 8'h01, 5'd0};
      tbl[4] = '{1'b0, 8'h80, 5'd0};
      for (int i = 0; i < 16; i++)
         tbl[5+i] = '{1'b1, l1[i], 5'(i + 1)};

      // Reset state
      repeat (3) @(negedge CLK);
      chk("rst_cursor", CURSOR, 5'd0);
      chk("rst_tv", TIME_VALID, 1'b0);
      chk("rst_alarm", ALARM_DET, 1'b0);
      chk("rst_h10", H10, 4'hF);
      chk("rst_s1", S1, 4'hF);
      chk("rst_err", ERR, 1'b0);
      chk("rst_runt", RUNT, 1'b0);
      chk_cell(0, 8'h20);
      RESETN = 1'b1;

      // Clock screen on line 1
      for (int i = 0; i < 21; i++) begin
         send(tbl[i].rs, tbl[i].data, 4);
         chk($sformatf("tbl%0d_cursor", i), CURSOR, tbl[i].cur);
      end
      chk("h10", H10, 4'd1);
      chk("h1", H1, 4'd2);
      chk("m10", M10, 4'd3);
      chk("m1", M1, 4'd4);
      chk("s10", S10, 4'd5);
      chk("s1", S1, 4'd6);
      chk("tv", TIME_VALID, 1'b1);
      chk("alarm_pre", ALARM_DET, 1'b0);

      // Alarm banner on line 2, cursor wraps 31 -> 0
      send(1'b0, 8'hC0, 4);
      chk("c0_cursor", CURSOR, 5'd16);
      send_str("  TIME IS OVER  ");
      chk("alarm", ALARM_DET, 1'b1);
      chk("wrap_cursor", CURSOR, 5'd0);
      chk("tv_kept", TIME_VALID, 1'b1);
      send(1'b0, 8'h01, 4);
      chk("clr_alarm", ALARM_DET, 1'b0);
      chk("clr_tv", TIME_VALID, 1'b0);
      chk("clr_h10", H10, 4'hF);
      for (int a = 0; a < 32; a++) chk_cell(a, 8'h20);

      // Illegal DDRAM address
      send(1'b0, 8'h85, 4);
      chk("85_cursor", CURSOR, 5'd5);
      send(1'b0, 8'h95, 4);
      chk("err_set", ERR, 1'b1);
      chk("err_cursor", CURSOR, 5'd5);
      send(1'b0, 8'h80, 4);
      chk("err_sticky", ERR, 1'b1);
      chk("80_cursor", CURSOR, 5'd0);

      // Pulse exactly E_MIN_HIGH is accepted
      send(1'b1, 8'h5A, 2);
      chk("min_runt", RUNT, 1'b0);
      chk("min_cursor", CURSOR, 5'd1);
      chk_cell(0, 8'h5A);

      // Runt pulse: flag only
      send(1'b1, 8'h41, 1);
      chk("runt_set", RUNT, 1'b1);
      chk("runt_cursor", CURSOR, 5'd1);
      chk_cell(1, 8'h20);

      // Decrement entry mode, then increment across line boundary
      send(1'b0, 8'h04, 4);
      send(1'b0, 8'h80, 4);
      send(1'b1, 8'h41, 4);
      chk_cell(0, 8'h41);
      chk("dec_cursor", CURSOR, 5'd31);
      send(1'b0, 8'h06, 4);
      send(1'b0, 8'h8F, 4);
      send(1'b1, 8'h42, 4);
      send(1'b1, 8'h43, 4);
      chk_cell(15, 8'h42);
      chk_cell(16, 8'h43);
      chk("inc_cursor", CURSOR, 5'd17);
      chk("runt_sticky", RUNT, 1'b1);

      // Reset mid-write: strobe lost, short tail is a runt
      @(negedge CLK);
      LCD_RS = 1'b1;
      LCD_DATA = 8'h5A;
      LCD_E = 1'b1;
      repeat (2) @(negedge CLK);
      RESETN = 1'b0;
      #1;
      chk("mrst_cursor", CURSOR, 5'd0);
      chk("mrst_err", ERR, 1'b0);
      chk("mrst_runt", RUNT, 1'b0);
      chk("mrst_tv", TIME_VALID, 1'b0);
      chk("mrst_alarm", ALARM_DET, 1'b0);
      chk("mrst_h10", H10, 4'hF);
      chk_cell(16, 8'h20);
      @(negedge CLK);
      RESETN = 1'b1;
      @(negedge CLK);
      LCD_E = 1'b0;
      @(negedge CLK);
      chk("post_runt", RUNT, 1'b1);
      chk("post_cursor", CURSOR, 5'd0);
      chk_cell(0, 8'h20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lcd_bus_monitor.md
LCD_BUS_MONITOR -- requirements
Module: lcd_bus_monitor

Interface
REQ-001 SHALL have parameter: E_MIN_HIGH, default 2, the minimum number of consecutive CLK cycles LCD_E must be high for a strobe to count (range 1..65535).
REQ-002 SHALL have port: CLK  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port: RESETN  input  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
REQ-004 SHALL have port: LCD_DATA  input  8  observed LCD data bus.
REQ-005 SHALL have port: LCD_E  input  1  observed LCD enable, synchronous to CLK.
REQ-006 SHALL have port: LCD_RS  input  1  observed register select (0 = command, 1 = character).
REQ-007 SHALL have port: RD_ADDR  input  5  shadow-display read address (0-15 line 1, 16-31 line 2).
REQ-008 SHALL have port: RD_CHAR  output  8  shadow cell at RD_ADDR, combinational.
REQ-009 SHALL have port: H10, H1, M10, M1, S10, S1  output  4 each  decoded time digits.
REQ-010 SHALL have port: TIME_VALID  output  1  line 1 holds a well-formed time.
REQ-011 SHALL have port: ALARM_DET  output  1  line 2 shows "TIME IS OVER".
REQ-012 SHALL have port: CURSOR  output  5  current write position.
REQ-013 SHALL have port: ERR  output  1  sticky flag for an illegal DDRAM address.
REQ-014 SHALL have port: RUNT  output  1  sticky flag for an LCD_E pulse shorter than E_MIN_HIGH.

Function
REQ-015 SHALL register LCD_DATA, LCD_RS and LCD_E every cycle into D_q, RS_q and E_q.
REQ-016 SHALL count consecutive cycles with LCD_E=1 in a 16-bit high counter, saturating, cleared when LCD_E=0.
REQ-017 SHALL define the strobe as E_q=1 and LCD_E=0 (falling edge), acting on D_q and RS_q, i.e. the values from the last high cycle.
REQ-018 SHALL treat a falling edge with high count < E_MIN_HIGH as a runt: set RUNT and make no other state change.
REQ-019 SHALL apply a valid strobe on that same rising edge, so the updated shadow and CURSOR are visible the next cycle.
REQ-020 SHALL hold 32 x 8-bit shadow cells and a 1-bit increment flag ENTRY_INC.
REQ-021 SHALL execute command (RS_q=0) 0x01 as: all 32 cells <= 0x20, CURSOR <= 0, ENTRY_INC <= 1.
REQ-022 SHALL execute command 0x02 or 0x03 as: CURSOR <= 0, cells unchanged.
REQ-023 SHALL execute command 0x04 or 0x05 as ENTRY_INC <= 0, and 0x06 or 0x07 as ENTRY_INC <= 1.
REQ-024 SHALL execute command 0x80|a as: a=0x00-0x0F -> CURSOR <= a; a=0x40-0x4F -> CURSOR <= 16+(a-0x40); any other a -> ERR <= 1 with CURSOR unchanged.
REQ-025 SHALL ignore all other commands (including 0x38 and 0x0F) without error.
REQ-026 SHALL execute a character write (RS_q=1) as: cell[CURSOR] <= D_q, then CURSOR moves +1 if ENTRY_INC, else -1, modulo 32 (31->0, 0->31, 15->16 continuous).
REQ-027 SHALL decode each digit output from its cell: H10=cell2, H1=cell3, M10=cell7, M1=cell8, S10=cell12, S1=cell13.
REQ-028 SHALL map ASCII 0x30-0x39 to 0-9 and any other character to 4'hF.
REQ-029 SHALL drive TIME_VALID=1 iff all six digits are not 4'hF and cell5 = cell10 = 0x3A.
REQ-030 SHALL drive ALARM_DET=1 iff cells 18-29 equal "TIME IS OVER" (54 49 4D 45 20 49 53 20 4F 56 45 52).
REQ-031 SHALL make digits, TIME_VALID and ALARM_DET combinational from the shadow cells, with no added latency.
REQ-032 SHALL make ERR and RUNT sticky; only reset clears them.

Reset
REQ-033 SHALL, on RESETN=0, immediately set: all cells 0x20, CURSOR=0, ENTRY_INC=1, ERR=0, RUNT=0, high counter 0, E_q=D_q=RS_q=0; consequently digits=4'hF, TIME_VALID=0, ALARM_DET=0.
REQ-034 SHALL lose any strobe in progress when reset asserts mid-pulse; a falling edge of LCD_E after reset release with count < E_MIN_HIGH sets RUNT.

Verification
REQ-035 SHALL pass: sequence 0x38,0x0F,0x06,0x01,0x80 (RS=0), then "  12 : 34 : 56  " (RS=1), each E high 4 cycles -> H10..S1=1,2,3,4,5,6, TIME_VALID=1, CURSOR=16.
REQ-036 SHALL pass: 0xC0, then "  TIME IS OVER  " -> ALARM_DET=1, CURSOR wraps to 0; then 0x01 -> ALARM_DET=0, TIME_VALID=0, RD_CHAR=0x20 at all addresses.
REQ-037 SHALL pass: command 0x95 -> ERR=1, CURSOR unchanged; subsequent 0x80 -> ERR stays 1.
REQ-038 SHALL pass: E high 1 cycle with E_MIN_HIGH=2, DATA=0x41, RS=1 -> RUNT=1, cell[CURSOR] and CURSOR unchanged.
REQ-039 SHALL pass: 0x04, 0x80, write 'A' -> cell0=0x41, CURSOR=31; 0x06, 0x8F, write 'B','C' -> cell15=0x42, cell16=0x43, CURSOR=17.
REQ-040 SHALL pass: RESETN low for 1 cycle while E high mid-write -> all outputs at reset values, no cell written.
